// File: rtl/kernel_kcore_start_fifo_bcast.sv
// Broadcast start/token FIFO: one writer, NUM_CH independent first-word-fall-through readers.
// A slot is released only once the slowest channel has consumed it.
module kernel_kcore_start_fifo_bcast #(
    parameter int DATA_WIDTH  = 1,
    parameter int ADDR_WIDTH  = 2,
    parameter int DEPTH       = 4,
    parameter int NUM_CH      = 2,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         if_write_ce,
    input  logic                         if_write,
    input  logic [DATA_WIDTH-1:0]        if_din,
    output logic                         if_full_n,
    output logic                         if_almost_full_n,
    output logic [ADDR_WIDTH:0]          if_count,
    input  logic [NUM_CH-1:0]            if_read_ce,
    input  logic [NUM_CH-1:0]            if_read,
    output logic [NUM_CH-1:0]            if_empty_n,
    output logic [NUM_CH*DATA_WIDTH-1:0] if_dout
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr  [NUM_CH];
    cnt_t                  cnt     [NUM_CH];
    cnt_t                  nxt_cnt [NUM_CH];
    cnt_t                  nxt_occ;
    logic                  wr_acc;
    logic [NUM_CH-1:0]     rd_acc;

    // Explicit wrap keeps non-power-of-two DEPTH legal.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Accepts use only registered flags, so a full buffer never writes through on a read.
    assign wr_acc = if_write & if_write_ce & if_full_n;
    assign rd_acc = if_read & if_read_ce & if_empty_n;

    // NOTE: every output of this block is assigned a default before any branch, so no latch is inferred.
    always_comb begin
        nxt_occ = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_cnt[c] = cnt[c];
            if (wr_acc && !rd_acc[c])
                nxt_cnt[c] = cnt[c] + cnt_t'(1);
            else if (!wr_acc && rd_acc[c])
                nxt_cnt[c] = cnt[c] - cnt_t'(1);
            if (nxt_cnt[c] > nxt_occ)
                nxt_occ = nxt_cnt[c];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr           <= '0;
            if_empty_n       <= '0;
            if_full_n        <= 1'b1;
            if_almost_full_n <= (AFULL_LEVEL > 0);
            if_count         <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_acc[c])
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                cnt[c]        <= nxt_cnt[c];
                if_empty_n[c] <= (nxt_cnt[c] != '0);
            end
            if_full_n        <= (nxt_occ != cnt_t'(DEPTH));
            if_almost_full_n <= (nxt_occ < cnt_t'(AFULL_LEVEL));
            if_count         <= nxt_occ;
        end
    end

    // NOTE: storage has no reset; the counters alone decide which slots hold valid data.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= if_din;
    end

    always_comb begin
        if_dout = '0;
        for (int c = 0; c < NUM_CH; c++)
            if_dout[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr[c]];
    end

endmodule

// File: tb/tb_kernel_kcore_start_fifo_bcast.sv
// Scoreboard bench: a 2-channel DEPTH=4 instance and a 1-channel DEPTH=3 instance.
module tb_kernel_kcore_start_fifo_bcast;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // DEPTH=4, NUM_CH=2, DATA_WIDTH=2, AFULL_LEVEL=3
    logic       w_ce, w_en;
    logic [1:0] w_din;
    logic       full_n, afull_n;
    logic [2:0] count;
    logic [1:0] r_ce, r_en, empty_n;
    logic [3:0] dout;

    // DEPTH=3, NUM_CH=1, DATA_WIDTH=2, AFULL_LEVEL=2
    logic       w3_en, r3_en;
    logic [1:0] w3_din;
    logic       full3_n, afull3_n, empty3_n;
    logic [2:0] count3;
    logic [1:0] dout3;

    kernel_kcore_start_fifo_bcast #(
        .DATA_WIDTH(2), .ADDR_WIDTH(2), .DEPTH(4), .NUM_CH(2), .AFULL_LEVEL(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(w_ce), .if_write(w_en), .if_din(w_din),
        .if_full_n(full_n), .if_almost_full_n(afull_n), .if_count(count),
        .if_read_ce(r_ce), .if_read(r_en), .if_empty_n(empty_n), .if_dout(dout)
    );

    kernel_kcore_start_fifo_bcast #(
        .DATA_WIDTH(2), .ADDR_WIDTH(2), .DEPTH(3), .NUM_CH(1), .AFULL_LEVEL(2)
    ) dut3 (
        .clk(clk), .reset_n(reset_n),
        .if_write_ce(1'b1), .if_write(w3_en), .if_din(w3_din),
        .if_full_n(full3_n), .if_almost_full_n(afull3_n), .if_count(count3),
        .if_read_ce(1'b1), .if_read(r3_en), .if_empty_n(empty3_n), .if_dout(dout3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] q0[$], q1[$], q3[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the 2-channel instance: check flags against the model, drive, score reads.
    task automatic cyc(input logic wr, input logic [1:0] d, input logic [1:0] rd);
        int occ;
        logic wacc;
        @(negedge clk);
        occ = (q0.size() > q1.size()) ? q0.size() : q1.size();
        check("empty_n0", 32'(empty_n[0]), 32'(q0.size() != 0));
        check("empty_n1", 32'(empty_n[1]), 32'(q1.size() != 0));
        check("count", 32'(count), occ);
        check("full_n", 32'(full_n), 32'(occ != 4));
        check("afull_n", 32'(afull_n), 32'(occ < 3));
        w_en  = wr;
        w_din = d;
        r_en  = rd;
        wacc  = wr && w_ce && (occ < 4);
        if (rd[0] && r_ce[0] && q0.size() != 0) check("dout0", 32'(dout[1:0]), 32'(q0.pop_front()));
        if (rd[1] && r_ce[1] && q1.size() != 0) check("dout1", 32'(dout[3:2]), 32'(q1.pop_front()));
        if (wacc) begin
            q0.push_back(d);
            q1.push_back(d);
        end
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 2'b00;
    endtask

    task automatic cyc3(input logic wr, input logic [1:0] d, input logic rd);
        int occ;
        @(negedge clk);
        occ = q3.size();
        check("d3_empty_n", 32'(empty3_n), 32'(occ != 0));
        check("d3_count", 32'(count3), occ);
        check("d3_full_n", 32'(full3_n), 32'(occ != 3));
        check("d3_afull_n", 32'(afull3_n), 32'(occ < 2));
        w3_en  = wr;
        w3_din = d;
        r3_en  = rd;
        if (rd && occ != 0) check("d3_dout", 32'(dout3), 32'(q3.pop_front()));
        if (wr && occ < 3) q3.push_back(d);
        @(posedge clk);
        #1;
        w3_en = 1'b0;
        r3_en = 1'b0;
    endtask

    initial begin
        w_ce = 1'b1; w_en = 1'b0; w_din = '0; r_ce = 2'b11; r_en = 2'b00;
        w3_en = 1'b0; w3_din = '0; r3_en = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Fill to 3, both channels drain in order.
        cyc(1, 2'd1, 2'b00);
        cyc(1, 2'd2, 2'b00);
        cyc(1, 2'd3, 2'b00);
        repeat (3) cyc(0, 2'd0, 2'b11);
        cyc(0, 2'd0, 2'b00);

        // Channel 1 stalls while channel 0 drains; buffer fills, extra write dropped.
        for (int i = 0; i < 4; i++) cyc(1, 2'(i), 2'b01);
        cyc(0, 2'd0, 2'b01);
        cyc(1, 2'd3, 2'b00);
        // Full: channel 1 read alongside a write request; write must not go through.
        cyc(1, 2'd2, 2'b10);
        repeat (3) cyc(0, 2'd0, 2'b10);

        // Write-enable gating.
        w_ce = 1'b0;
        cyc(1, 2'd1, 2'b00);
        w_ce = 1'b1;

        // Steady state at occupancy 2 with pointer wrap.
        cyc(1, 2'd2, 2'b00);
        cyc(1, 2'd1, 2'b00);
        for (int i = 0; i < 10; i++) cyc(1, 2'(i + 3), 2'b11);
        repeat (2) cyc(0, 2'd0, 2'b11);

        // Steady state at occupancy DEPTH-1.
        for (int i = 0; i < 3; i++) cyc(1, 2'(i), 2'b00);
        for (int i = 0; i < 6; i++) cyc(1, 2'(i + 1), 2'b11);

        // Random traffic with random read enables.
        for (int i = 0; i < 60; i++) begin
            r_ce = 2'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        r_ce = 2'b11;
        repeat (5) cyc(0, 2'd0, 2'b11);

        // Asynchronous reset mid-stream.
        cyc(1, 2'd2, 2'b00);
        cyc(1, 2'd1, 2'b00);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_empty_n", 32'(empty_n), 32'd0);
        check("rst_full_n", 32'(full_n), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_afull_n", 32'(afull_n), 32'd1);
        q0.delete();
        q1.delete();
        q3.delete();
        @(posedge clk);
        #1 check("rst_hold_count", 32'(count), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        cyc(1, 2'd3, 2'b00);
        cyc(0, 2'd0, 2'b11);
        cyc(0, 2'd0, 2'b00);

        // Non-power-of-two depth.
        for (int i = 0; i < 7; i++) begin
            cyc3(1, 2'(i + 1), 0);
            cyc3(0, 2'd0, 1);
        end
        for (int i = 0; i < 4; i++) cyc3(1, 2'(3 - i), 0);
        cyc3(1, 2'd0, 1);
        repeat (3) cyc3(0, 2'd0, 1);
        cyc3(0, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
